ber_counter: RTL and testbench
==============================

// Module: ber_counter
// PURPOSE
//  Bit-error counter for one QPSK branch (instantiate once for I, once for Q) inside qpsk_comm_sys.
//  Consumes slicer decisions and the transmitter PRBS reference bit at rate one.
//  Searches for the channel delay, locks to it, then accumulates total and errored bits.
//  Feeds the 64-bit o_accum_err_* / o_accum_tot_* counters latched by the GPIO register file.
// PARAMETERS
//  N_DELAY      250  number of candidate reference delays searched (taps 0..N_DELAY-1)
//  SYNC_WIN     511  symbols compared per candidate delay during search
//  NBT_COUNT    64   width of accumulators
// PORTS
//  clk           in   1          system clock; all logic on posedge
//  i_reset       in   1          synchronous, active-high reset
//  i_enbl        in   1          rate-one strobe; logic advances only when high
//  i_bit_ref     in   1          transmitted reference bit (PRBS)
//  i_bit_rx      in   1          received bit (slicer sign)
//  o_accum_err   out  NBT_COUNT  errored bits since lock
//  o_accum_tot   out  NBT_COUNT  compared bits since lock
//  o_delay       out  clog2(N_DELAY)  selected delay
//  o_locked      out  1          high in COUNT state
// BEHAVIOUR
//  Reset: all outputs 0, delay line 0, state SEARCH, candidate 0, best_err = all-ones.
//  i_enbl low: every register holds (including delay line); no counting.
//  Delay line: on i_enbl, shifts in i_bit_ref; tap k = reference delayed by k enables (tap 0 = current i_bit_ref).
//  Compare bit e = i_bit_rx XOR tap[d], d = candidate (SEARCH) or o_delay (COUNT).
//  SEARCH: win_cnt counts SYNC_WIN enables at candidate d, win_err sums e.
//   End of window: if win_err < best_err (strict; tie keeps lower d) store best_err, best_d.
//   Then d+1, counters cleared; after d = N_DELAY-1 -> o_delay <= best_d, state COUNT.
//   Search length exactly N_DELAY*SYNC_WIN enables; o_locked rises the cycle after the last one.
//  COUNT: per enable, o_accum_tot += 1, o_accum_err += e; updated value visible next cycle (latency 1).
//   Accumulators saturate at all-ones, never wrap; err and tot saturate independently.
//  First compared bit in COUNT is the enable following lock.
//  Reset mid-search or mid-count: immediate return to reset state, counters cleared.
// CONFIGURATION
//  BER_RESYNC_EN defined: in COUNT, a SYNC_WIN window with errors > SYNC_WIN/4 returns to SEARCH
//   (candidate 0, best_err all-ones, o_locked low); accumulators hold, not cleared.
//  BER_RESYNC_EN undefined: COUNT is terminal until reset; no window logic synthesized.
// STRUCTURE
//  Shared package ber_pkg: state encodings (SEARCH, COUNT), clog2 helper, resync threshold constant.
//  Sub-module bit_delay_line (N_DELAY-deep shift register, enable, tap select mux).
//  FSM, window counters, accumulators live in ber_counter.
// TESTING (small params N_DELAY=16, SYNC_WIN=31 unless noted)
//  rx = ref delayed 7, i_enbl=1 -> o_locked after 496 enables, o_delay=7, err stays 0, tot increments 1/cycle.
//  same + rx flipped every 10th COUNT bit -> after 1000 COUNT enables err=100, tot=1000.
//  i_enbl toggled 1-of-4 cycles -> identical lock and counts measured in enables, registers hold in gaps.
//  rx = ~ref (all wrong at every delay) -> tie at all candidates, o_delay=0, err==tot thereafter.
//  i_reset pulsed mid-search and mid-count -> next cycle outputs 0, o_locked 0, search restarts at 0.
//  NBT_COUNT=8, all errors -> err and tot stick at 255; BER_RESYNC_EN with delay changed 7->3 -> relock o_delay=3.

Source files
------------

// File: rtl/ber_pkg.sv
// Shared definitions for the BER counter: state codes, clog2 helper, resync threshold.
// Optional re-synchronisation is enabled with the BER_RESYNC_EN macro.
package ber_pkg;

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] COUNT  = 1'b1;

  localparam int RESYNC_DIV = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int resync_thr(input int win);
    return win / RESYNC_DIV;
  endfunction

endpackage

// File: rtl/bit_delay_line.sv
// Reference-bit delay line with enable and tap select.
// Tap 0 is the live input; tap k is the input k enables ago.
module bit_delay_line
  import ber_pkg::*;
#(
  parameter int N_DELAY = 250,
  parameter int DW      = clog2(N_DELAY)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enbl,
  input  logic          din,
  input  logic [DW-1:0] sel,
  output logic          tap
);

  logic [N_DELAY-2:0] sr;
  logic [N_DELAY-1:0] taps;

  assign taps = {sr, din};
  assign tap  = taps[sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (enbl) begin
      sr <= taps[N_DELAY-2:0];
    end
  end

endmodule

// File: rtl/ber_counter.sv
// Bit-error counter: searches the channel delay, locks, then accumulates bits/errors.
// With BER_RESYNC_EN defined, an error-heavy window in COUNT restarts the search.
module ber_counter
  import ber_pkg::*;
#(
  parameter int N_DELAY   = 250,
  parameter int SYNC_WIN  = 511,
  parameter int NBT_COUNT = 64
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic                      i_enbl,
  input  logic                      i_bit_ref,
  input  logic                      i_bit_rx,
  output logic [NBT_COUNT-1:0]      o_accum_err,
  output logic [NBT_COUNT-1:0]      o_accum_tot,
  output logic [clog2(N_DELAY)-1:0] o_delay,
  output logic                      o_locked
);

  localparam int DW = clog2(N_DELAY);
  localparam int CW = clog2(SYNC_WIN);
  localparam int EW = clog2(SYNC_WIN + 1);

  logic [0:0]    state;
  logic [DW-1:0] cand;
  logic [DW-1:0] best_d;
  logic [DW-1:0] sel;
  logic [CW-1:0] win_cnt;
  logic [EW-1:0] win_err;
  logic [EW-1:0] best_err;
  logic [EW-1:0] err_nxt;
  logic          tap;
  logic          e;
  logic          win_end;
  logic          last_cand;
  logic          better;

  bit_delay_line #(
    .N_DELAY (N_DELAY),
    .DW      (DW)
  ) u_dly (
    .clk   (clk),
    .reset (i_reset),
    .enbl  (i_enbl),
    .din   (i_bit_ref),
    .sel   (sel),
    .tap   (tap)
  );

  assign sel       = (state == COUNT) ? o_delay : cand;
  assign e         = i_bit_rx ^ tap;
  assign err_nxt   = win_err + EW'(e);
  assign win_end   = (win_cnt == CW'(SYNC_WIN - 1));
  assign last_cand = (cand == DW'(N_DELAY - 1));
  assign better    = (err_nxt < best_err);
  assign o_locked  = (state == COUNT);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state       <= SEARCH;
      cand        <= '0;
      best_d      <= '0;
      best_err    <= '1;
      win_cnt     <= '0;
      win_err     <= '0;
      o_delay     <= '0;
      o_accum_err <= '0;
      o_accum_tot <= '0;
    end else if (i_enbl) begin
      unique case (1'b1)
        (state == SEARCH): begin
          if (win_end) begin
            win_cnt <= '0;
            win_err <= '0;
            if (better) begin
              best_err <= err_nxt;
              best_d   <= cand;
            end
            // The final window's result must be folded in before locking
            if (last_cand) begin
              o_delay <= better ? cand : best_d;
              state   <= COUNT;
              cand    <= '0;
            end else begin
              cand <= cand + 1'b1;
            end
          end else begin
            win_cnt <= win_cnt + 1'b1;
            win_err <= err_nxt;
          end
        end
        default: begin
          if (~&o_accum_tot) o_accum_tot <= o_accum_tot + 1'b1;
          if (e && ~&o_accum_err) o_accum_err <= o_accum_err + 1'b1;
`ifdef BER_RESYNC_EN
          if (win_end) begin
            win_cnt <= '0;
            win_err <= '0;
            if (err_nxt > EW'(resync_thr(SYNC_WIN))) begin
              state    <= SEARCH;
              cand     <= '0;
              best_d   <= '0;
              best_err <= '1;
            end
          end else begin
            win_cnt <= win_cnt + 1'b1;
            win_err <= err_nxt;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ber_counter.sv
// Directed bench for ber_counter (N_DELAY=16, SYNC_WIN=31; 64- and 8-bit counters).
// Reference bits come from a PRBS7 model; rx is built from the bench's own delay history.
module tb_ber_counter;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_enbl;
  logic        i_bit_ref;
  logic        i_bit_rx;
  logic [63:0] err64;
  logic [63:0] tot64;
  logic [3:0]  dly64;
  logic        lk64;
  logic [7:0]  err8;
  logic [7:0]  tot8;
  logic [3:0]  dly8;
  logic        lk8;

  int          checks = 0;
  int          fails  = 0;
  int          nbits;
  int          dly;
  bit          inv;
  bit          constref;
  logic [15:0] hist;
  logic [6:0]  lfsr;

  always #5 clk = ~clk;

  ber_counter #(
    .N_DELAY   (16),
    .SYNC_WIN  (31),
    .NBT_COUNT (64)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_enbl      (i_enbl),
    .i_bit_ref   (i_bit_ref),
    .i_bit_rx    (i_bit_rx),
    .o_accum_err (err64),
    .o_accum_tot (tot64),
    .o_delay     (dly64),
    .o_locked    (lk64)
  );

  ber_counter #(
    .N_DELAY   (16),
    .SYNC_WIN  (31),
    .NBT_COUNT (8)
  ) dut8 (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_enbl      (i_enbl),
    .i_bit_ref   (i_bit_ref),
    .i_bit_rx    (i_bit_rx),
    .o_accum_err (err8),
    .o_accum_tot (tot8),
    .o_delay     (dly8),
    .o_locked    (lk8)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit en, input bit flip);
    bit r;
    r = constref ? 1'b0 : lfsr[6];
    i_enbl = en;
    if (en) begin
      i_bit_ref = r;
      i_bit_rx  = (dly == 0 ? r : hist[dly-1]) ^ inv ^ flip;
    end else begin
      i_bit_ref = 1'($urandom);
      i_bit_rx  = 1'($urandom);
    end
    @(posedge clk);
    #1;
    if (en) begin
      hist = {hist[14:0], r};
      lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
  endtask

  task automatic run(input int n, input int gap, input int fe);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0);
      nbits++;
      step(1'b1, fe != 0 && (nbits % fe) == 0);
    end
  endtask

  task automatic do_reset;
    i_reset = 1'b1;
    i_enbl  = 1'b0;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    hist    = '0;
  endtask

  initial begin
    i_reset   = 1'b0;
    i_enbl    = 1'b0;
    i_bit_ref = 1'b0;
    i_bit_rx  = 1'b0;
    dly       = 7;
    inv       = 1'b0;
    constref  = 1'b0;
    hist      = '0;
    lfsr      = 7'h01;
    nbits     = 0;
    @(posedge clk);
    #1;

    // reset state
    do_reset;
    chk("rst_err", err64, 0);
    chk("rst_tot", tot64, 0);
    chk("rst_lock", 64'(lk64), 0);
    chk("rst_dly", 64'(dly64), 0);

    // delay 7, continuous enable
    run(495, 0, 0);
    chk("a_prelock", 64'(lk64), 0);
    run(1, 0, 0);
    chk("a_lock", 64'(lk64), 1);
    chk("a_lock8", 64'(lk8), 1);
    chk("a_dly", 64'(dly64), 7);
    chk("a_dly8", 64'(dly8), 7);
    chk("a_err0", err64, 0);
    chk("a_tot0", tot64, 0);
    nbits = 0;
    run(1, 0, 10);
    chk("a_tot1", tot64, 1);
    chk("a_err1", err64, 0);
    run(999, 0, 10);
    chk("a_err1000", err64, 100);
    chk("a_tot1000", tot64, 1000);
    chk("a_tot8_sat", 64'(tot8), 255);
    chk("a_err8", 64'(err8), 100);

    // reset mid-count
    do_reset;
    chk("rc_lock", 64'(lk64), 0);
    chk("rc_tot", tot64, 0);
    chk("rc_err", err64, 0);
    chk("rc_dly", 64'(dly64), 0);

    // enable 1-of-4 cycles
    run(495, 3, 0);
    for (int g = 0; g < 3; g++) step(1'b0, 1'b0);
    chk("b_gap_prelock", 64'(lk64), 0);
    step(1'b1, 1'b0);
    chk("b_lock", 64'(lk64), 1);
    chk("b_dly", 64'(dly64), 7);
    nbits = 0;
    run(40, 3, 10);
    chk("b_err40", err64, 4);
    chk("b_tot40", tot64, 40);
    for (int g = 0; g < 3; g++) step(1'b0, 1'b0);
    chk("b_hold_tot", tot64, 40);
    chk("b_hold_err", err64, 4);

    // all bits wrong at every delay, reset mid-search
    do_reset;
    constref = 1'b1;
    inv      = 1'b1;
    dly      = 0;
    run(100, 0, 0);
    do_reset;
    chk("c_rs_lock", 64'(lk64), 0);
    chk("c_rs_tot", tot64, 0);
    run(495, 0, 0);
    chk("c_prelock", 64'(lk64), 0);
    run(1, 0, 0);
    chk("c_lock", 64'(lk64), 1);
    chk("c_dly_tie", 64'(dly64), 0);
`ifndef BER_RESYNC_EN
    run(300, 0, 0);
    chk("c_err300", err64, 300);
    chk("c_tot300", tot64, 300);
    chk("c_err8_sat", 64'(err8), 255);
    chk("c_tot8_sat", 64'(tot8), 255);
`else
    // channel delay moves 7 -> 3 after lock
    do_reset;
    constref = 1'b0;
    inv      = 1'b0;
    dly      = 7;
    run(496, 0, 0);
    chk("r_lock", 64'(lk64), 1);
    chk("r_dly", 64'(dly64), 7);
    dly = 3;
    for (int i = 0; i < 100 && lk64; i++) run(1, 0, 0);
    chk("r_unlock", 64'(lk64), 0);
    for (int i = 0; i < 600 && !lk64; i++) run(1, 0, 0);
    chk("r_relock", 64'(lk64), 1);
    chk("r_dly3", 64'(dly64), 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
